// File: rtl/lock_pkg.sv
// Shared definitions for the keypad lockout sequencer.
//   lock_state_t : sequencer state (IDLE, LOCKED, ALARM)
//   SW_DEF       : default width of the seconds-remaining counter
//   ATT_W        : width of the wrong-attempt counter output
//   sat_shl()    : left shift that clamps to the largest w-bit value
package lock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        ALARM  = 2'd2
    } lock_state_t;

    localparam int SW_DEF = 8;
    localparam int ATT_W  = 4;

    // base << sh, clamped to 2^w - 1. Intended for w <= 31.
    function automatic logic [31:0] sat_shl(input logic [31:0] base,
                                            input int unsigned sh,
                                            input int unsigned w);
        logic [63:0] wide;
        logic [63:0] lim;
        lim = (64'd1 << w) - 64'd1;
        if (sh >= 32)
            wide = (base == 32'd0) ? 64'd0 : lim;
        else
            wide = {32'd0, base} << sh;
        if (wide > lim)
            wide = lim;
        return wide[31:0];
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Seconds prescaler: counts 0..CLK_PER_SEC-1 while en is high and emits a
// one-cycle tick on the cycle the count wraps. Held at 0 whenever en is low.
//   clk   : system clock
//   reset : synchronous active-high reset
//   en    : run enable
//   tick  : one-cycle pulse on the wrap cycle
module sec_tick_gen #(
    parameter int CLK_PER_SEC = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_PER_SEC - 1);

    logic [CW-1:0] cnt_reg;

    assign tick = en && (cnt_reg == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset || !en)
            cnt_reg <= '0;
        else if (tick)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_reg + 1'b1;
    end

endmodule

// File: rtl/pin_lockout_ctrl.sv
// Attempt and lockout sequencer for the keypad lock. Counts consecutive wrong
// PINs, blocks the keypad for a doubling number of seconds after every
// MAX_ATTEMPTS failures, and latches ALARM after MAX_LOCKOUTS lockouts.
//   clk, reset : clock and synchronous active-high reset
//   pin_valid  : one-cycle pulse, PIN entry evaluated
//   pin_ok     : qualifies pin_valid, 1 = correct PIN
//   clear_req  : master clear level from the hold-to-reset detector
//   unlock     : one-cycle pulse on an accepted correct PIN
//   locked     : keypad blocked (LOCKED or ALARM)
//   alarm      : ALARM state
//   attempts   : wrong entries since last success/lockout
//   secs_left  : lockout seconds remaining, 0 outside LOCKED
module pin_lockout_ctrl
    import lock_pkg::*;
#(
    parameter int CLK_PER_SEC  = 1000,
    parameter int MAX_ATTEMPTS = 3,
    parameter int LOCK_BASE_S  = 10,
    parameter int MAX_LOCKOUTS = 3,
    parameter int SW           = SW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pin_valid,
    input  logic             pin_ok,
    input  logic             clear_req,
    output logic             unlock,
    output logic             locked,
    output logic             alarm,
    output logic [ATT_W-1:0] attempts,
    output logic [SW-1:0]    secs_left
);

    localparam int LC_W = $clog2(MAX_LOCKOUTS + 1);
    localparam int LC_N = 2 ** LC_W;

    lock_state_t      state_reg, state_next;
    logic [ATT_W-1:0] att_reg, att_next;
    logic [LC_W-1:0]  lo_cnt_reg, lo_cnt_next;
    logic [SW-1:0]    secs_reg, secs_next;
    logic             unlock_reg, unlock_next;
    logic             locked_reg, locked_next;
    logic             alarm_reg, alarm_next;
    logic             tick;
    logic             presc_en;

    // Lockout duration indexed by the lockout count before the increment,
    // i.e. entry gi is LOCK_BASE_S << gi, saturated to SW bits.
    logic [SW-1:0] lock_dur [LC_N];

    generate
        for (genvar gi = 0; gi < LC_N; gi++) begin : g_dur
            localparam logic [31:0] DUR32 = sat_shl(32'(LOCK_BASE_S), gi, SW);
            assign lock_dur[gi] = DUR32[SW-1:0];
        end
    endgenerate

    // Prescaler is also zeroed in the clear cycle, so a clear during LOCKED
    // leaves it at 0 for the next lockout.
    assign presc_en = (state_reg == LOCKED) && !clear_req;

    sec_tick_gen #(
        .CLK_PER_SEC (CLK_PER_SEC)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (presc_en),
        .tick  (tick)
    );

    // State and counter registers, plus registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            att_reg    <= '0;
            lo_cnt_reg <= '0;
            secs_reg   <= '0;
            unlock_reg <= 1'b0;
            locked_reg <= 1'b0;
            alarm_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            att_reg    <= att_next;
            lo_cnt_reg <= lo_cnt_next;
            secs_reg   <= secs_next;
            unlock_reg <= unlock_next;
            locked_reg <= locked_next;
            alarm_reg  <= alarm_next;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        logic [ATT_W-1:0] att_inc;
        logic [LC_W-1:0]  lo_inc;
        state_next  = state_reg;
        att_next    = att_reg;
        lo_cnt_next = lo_cnt_reg;
        secs_next   = secs_reg;
        att_inc     = att_reg + 1'b1;
        lo_inc      = lo_cnt_reg + 1'b1;

        if (clear_req) begin
            state_next  = IDLE;
            att_next    = '0;
            lo_cnt_next = '0;
            secs_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pin_valid) begin
                        if (pin_ok) begin
                            att_next    = '0;
                            lo_cnt_next = '0;
                        end else if (att_inc != ATT_W'(MAX_ATTEMPTS)) begin
                            att_next = att_inc;
                        end else begin
                            att_next    = '0;
                            lo_cnt_next = lo_inc;
                            if (lo_inc == LC_W'(MAX_LOCKOUTS)) begin
                                state_next = ALARM;
                                secs_next  = '0;
                            end else begin
                                state_next = LOCKED;
                                secs_next  = lock_dur[lo_cnt_reg];
                            end
                        end
                    end
                end
                LOCKED: begin
                    if (tick) begin
                        if (secs_reg <= SW'(1)) begin
                            secs_next  = '0;
                            state_next = IDLE;
                        end else begin
                            secs_next = secs_reg - 1'b1;
                        end
                    end
                end
                ALARM: begin
                    secs_next = '0;
                end
                default: begin
                    state_next = IDLE;
                    secs_next  = '0;
                end
            endcase
        end
    end

    // Output logic, registered alongside the state.
    always_comb begin
        unlock_next = !clear_req && (state_reg == IDLE) && pin_valid && pin_ok;
        locked_next = (state_next != IDLE);
        alarm_next  = (state_next == ALARM);
    end

    assign unlock    = unlock_reg;
    assign locked    = locked_reg;
    assign alarm     = alarm_reg;
    assign attempts  = att_reg;
    assign secs_left = secs_reg;

endmodule
